// File: rtl/prbs31_seq_ctrl.sv
// Sequencing controller for the PRBS31 generator/checker: seeds, paces, bursts, drains, counts errors.
// Optional first-error index capture is built only when PRBS31_CTRL_FIRST_ERR_EN is defined.
module prbs31_seq_ctrl #(
  parameter int LEN_W   = 16,
  parameter int ERR_W   = 8,
  parameter int CHK_LAT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [30:0]      i_seed,
  input  logic [LEN_W-1:0] i_burst_len,
  input  logic [3:0]       i_div,
  input  logic             i_chk_valid,
  input  logic             i_chk_err,
  output logic             o_gen_load,
  output logic [30:0]      o_gen_seed,
  output logic             o_gen_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_bit_cnt,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [LEN_W-1:0] o_first_err_idx
);

  localparam int DRN_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(CHK_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [3:0]       r_div;
  logic [3:0]       r_div_cnt;
  logic [DRN_W-1:0] r_drain_cnt;
  logic             r_gen_load;
  logic [30:0]      r_gen_seed;
  logic             r_gen_en;
  logic             r_busy;
  logic             r_done;
  logic [LEN_W-1:0] r_bit_cnt;
  logic [ERR_W-1:0] r_err_cnt;

  logic             w_start_acc;
  logic             w_err_hit;
  logic [LEN_W-1:0] w_bit_inc;
  logic             w_last_bit;
  logic [3:0]       w_div_nxt;

  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_err_hit   = i_chk_valid && i_chk_err &&
                       ((r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DRAIN));
  assign w_bit_inc   = r_bit_cnt + LEN_W'(1);
  assign w_last_bit  = r_gen_en && (r_len != '0) && (w_bit_inc == r_len);
  assign w_div_nxt   = (r_div_cnt == 4'd0) ? r_div : (r_div_cnt - 4'd1);

  // gen_en is registered, so each edge decides whether the coming cycle issues a bit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_drain_cnt <= '0;
      r_gen_load  <= 1'b0;
      r_gen_seed  <= '0;
      r_gen_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bit_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_len      <= i_burst_len;
            r_div      <= i_div;
            r_gen_seed <= (i_seed == 31'd0) ? 31'd1 : i_seed;
            r_bit_cnt  <= '0;
            r_gen_load <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_LOAD: begin
          r_gen_load  <= 1'b0;
          r_div_cnt   <= '0;
          r_drain_cnt <= '0;
          if (i_abort) begin
            r_state <= S_DRAIN;
          end else begin
            r_state  <= S_RUN;
            r_gen_en <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_gen_en) begin
            r_bit_cnt <= w_bit_inc;
          end
          if (i_abort || w_last_bit) begin
            r_state     <= S_DRAIN;
            r_gen_en    <= 1'b0;
            r_drain_cnt <= '0;
          end else begin
            r_div_cnt <= w_div_nxt;
            r_gen_en  <= (w_div_nxt == 4'd0);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRN_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err_cnt <= '0;
    end else if (w_start_acc) begin
      r_err_cnt <= '0;
    end else if (w_err_hit && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

`ifdef PRBS31_CTRL_FIRST_ERR_EN
  logic [LEN_W-1:0] r_first_err_idx;

  // err_cnt only grows within a run, so zero means no error has been counted yet
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_first_err_idx <= '0;
    end else if (w_start_acc) begin
      r_first_err_idx <= '0;
    end else if (w_err_hit && (r_err_cnt == '0)) begin
      r_first_err_idx <= r_bit_cnt;
    end
  end

  assign o_first_err_idx = r_first_err_idx;
`else
  assign o_first_err_idx = '0;
`endif

  assign o_gen_load = r_gen_load;
  assign o_gen_seed = r_gen_seed;
  assign o_gen_en   = r_gen_en;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: doc/prbs31_seq_ctrl.md
# prbs31_seq_ctrl

Sequencing controller for the PRBS31 generator/checker datapath. It seeds the generator, paces bit generation with a programmable rate divider, and runs a finite or continuous burst. It counts checker-reported bit errors, drains the checker pipeline, and reports completion. It sits between the host-facing pin logic and the PRBS31 LFSR/checker pair inside the tt_um top.

## Interface
Parameters:
- LEN_W, 16: width of burst length and bit counter.
- ERR_W, 8: width of the saturating error counter.
- CHK_LAT, 4: checker pipeline latency in cycles (≥1); sets the DRAIN length.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a run; accepted only in IDLE or DONE.
- abort  in  1  end the run early; honoured only in LOAD or RUN.
- seed  in  31  generator seed; sampled when start is accepted.
- burst_len  in  LEN_W  bits to generate; 0 = continuous until abort; sampled at start.
- div  in  4  rate divider; one bit every div+1 cycles; sampled at start.
- chk_valid  in  1  checker result valid this cycle.
- chk_err  in  1  checker mismatch; qualified by chk_valid.
- gen_load  out  1  load gen_seed into the generator.
- gen_seed  out  31  seed to load.
- gen_en  out  1  advance the generator by one bit.
- busy  out  1  high in LOAD, RUN and DRAIN.
- done  out  1  high in DONE.
- bit_cnt  out  LEN_W  bits generated this run.
- err_cnt  out  ERR_W  errors counted this run; saturating.
- first_err_idx  out  LEN_W  bit_cnt value at the first error (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE/DONE + start → LOAD.
  - Latch burst_len and div.
  - gen_seed = seed, or 31'h0000_0001 if seed == 0, because an all-zero seed locks the LFSR.
  - Clear bit_cnt, err_cnt and first_err_idx.
- LOAD: gen_load = 1 for exactly one cycle.
  - Next state is RUN, or DRAIN if abort is high.
- RUN: a divider counter starts at 0.
  - gen_en = 1 when the divider is 0; the divider reloads with div and decrements otherwise.
  - Each gen_en increments bit_cnt.
  - On the gen_en that makes bit_cnt == burst_len (burst_len ≠ 0): → DRAIN.
  - With burst_len == 0, bit_cnt wraps modulo 2^LEN_W and the run continues until abort.
- abort in RUN: → DRAIN next cycle. A gen_en in that same cycle is still issued and counted.
- DRAIN: lasts exactly CHK_LAT cycles; gen_en = 0. Then → DONE.
- DONE: done = 1; counters hold. The next start re-arms via LOAD.
- start while busy is ignored. abort in IDLE, DONE or DRAIN is ignored.
- start and abort in the same cycle in IDLE/DONE: start is accepted, abort is ignored.
- Error counting: err_cnt += 1 when chk_valid & chk_err in LOAD, RUN or DRAIN.
  - err_cnt saturates at 2^ERR_W−1.
  - chk_valid outside those states is ignored.

## Timing
- Reset (rst_n low at a clock edge): state IDLE; every output is 0, including gen_seed, bit_cnt, err_cnt and first_err_idx.
- Reset mid-run aborts immediately, with no DRAIN; outputs are 0 on the next cycle.
- Latency:
  - start accepted at edge N → gen_load at N+1 → first gen_en at N+2.
  - With div = d, subsequent gen_en pulses come every d+1 cycles.
- For burst_len = L, RUN lasts (L−1)(d+1)+1 cycles. The last gen_en is in the final RUN cycle, followed by CHK_LAT DRAIN cycles; done rises on the cycle after DRAIN ends.
- busy and done are never high together and are registered outputs.

## Configuration
- Macro PRBS31_CTRL_FIRST_ERR_EN.
- Defined: on the first counted error of a run, first_err_idx captures the current bit_cnt and holds until the next start.
- Undefined: first_err_idx is tied to 0, and the capture register is not built.

## Test plan
- Reset then idle: hold rst_n low 2 cycles → all outputs 0, busy = 0, done = 0; chk_err pulses in IDLE leave err_cnt = 0.
- Finite burst, seed 31'h1234567, burst_len 8, div 0:
  - gen_load 1 cycle after start;
  - 8 consecutive gen_en;
  - 4 DRAIN cycles;
  - done with bit_cnt = 8, err_cnt = 0.
- Paced burst, burst_len 3, div 2 → gen_en at cycles N+2, N+5, N+8; done at N+13.
- Zero seed plus errors:
  - seed 0 → gen_seed = 31'h1;
  - inject 300 chk_valid & chk_err pulses during RUN (burst_len 0) → err_cnt saturates at 255;
  - abort → DRAIN → DONE.
- Abort/start priority:
  - start & abort in the same IDLE cycle → LOAD, run proceeds;
  - abort in RUN after bit 5 → bit_cnt = 5 or 6 per gen_en timing, then DRAIN 4 cycles, done;
  - start during RUN is ignored.
- With PRBS31_CTRL_FIRST_ERR_EN: first error at bit_cnt = 17 → first_err_idx = 17, held through later errors and cleared by the next start.
- Without the macro: first_err_idx stays 0.
